cache_control: RTL and testbench
================================

// Module: cache_control
// PURPOSE
// - FSM that sequences the 2-way set-associative cache datapath (tag/valid/dirty/data arrays, LRU bit).
// - Sits between the CPU memory port and physical memory; drives every datapath load/select strobe.
// - Resolves hits in the request cycle, handles misses (dirty writeback, then line fill) and keeps hit/miss/writeback counters.
// PARAMETERS
// - CNT_WIDTH  32  width of each saturating performance counter
// PORTS
// - clk                 in   1          clock; all state updates on rising edge
// - rst                 in   1          reset; synchronous, active-high
// - mem_read            in   1          CPU read request; held until mem_resp
// - mem_write           in   1          CPU write request; held until mem_resp
// - mem_resp            out  1          CPU request complete (one cycle)
// - pmem_resp           in   1          physical memory transaction complete
// - pmem_read           out  1          physical memory line read; held until pmem_resp
// - pmem_write          out  1          physical memory line write; held until pmem_resp
// - hit0 / hit1         in   1 each     way hit (valid & tag match), from datapath
// - dirty0 / dirty1     in   1 each     dirty bit of the indexed set, per way
// - lru_out             in   1          LRU way of the indexed set (1 = way1 is LRU)
// - load_valid0/1, load_dirty0/1, load_tag0/1, load_data0/1  out  1 each  per-way array write enables
// - load_lru            out  1          LRU write; the datapath records the accessed way
// - addr_sel            out  2          pmem address: 00 = CPU line address, 01 = {tag0,set}, 10 = {tag1,set}
// - datain_sel          out  1          0 = CPU write merge (sets dirty), 1 = pmem fill (clears dirty)
// - hit_count, miss_count, wb_count  out  CNT_WIDTH each  performance counters
// BEHAVIOUR
// - Datapath arrays read combinationally; hit0/hit1/dirty/lru_out are valid in the request cycle.
// - All outputs are combinational from state and inputs; no strobe is registered.
// - Default for every output is 0. addr_sel defaults to 00.
// - Reset: state = IDLE, victim = 0, replay = 0, all counters = 0.
// - States: IDLE, WRITEBACK, ALLOCATE.
// - IDLE, request, hit:
//   - mem_resp = 1 and load_lru = 1 in the same cycle; hit latency is 0 wait cycles.
//   - A write hit also asserts load_data<w> and load_dirty<w> with datain_sel = 0.
// - IDLE, request, miss (no hit):
//   - Latch victim = lru_out.
//   - Go to WRITEBACK if dirty<victim> = 1, else go to ALLOCATE.
//   - miss_count increments once per miss.
// - WRITEBACK:
//   - pmem_write = 1, addr_sel = 01 (victim 0) or 10 (victim 1).
//   - On pmem_resp: wb_count++ and go to ALLOCATE.
// - ALLOCATE:
//   - pmem_read = 1, addr_sel = 00.
//   - In the pmem_resp cycle: load_data/tag/valid/dirty<victim> = 1, datain_sel = 1; set replay = 1; go to IDLE.
// - Replay: the next IDLE cycle hits and responds.
//   - hit_count increments on IDLE hits only when replay = 0.
//   - replay clears on any IDLE mem_resp.
// - The victim is latched on leaving IDLE, so an lru_out change mid-miss has no effect.
// - CPU request dropped mid-miss: the pmem transaction still completes and the fill is written; IDLE then waits idle.
// - mem_read and mem_write both high: illegal; treated as a write.
// - hit0 and hit1 both high: illegal; way0 wins.
// - Reset during WRITEBACK or ALLOCATE:
//   - pmem_read/pmem_write drop in the cycle after rst is sampled.
//   - No array strobes are asserted.
//   - The physical memory side tolerates the abandoned transaction.
// - Counters saturate at all-ones and do not wrap.
// STRUCTURE
// - Package cache_types:
//   - state enum {IDLE, WRITEBACK, ALLOCATE}
//   - addr_sel constants ADDR_CPU = 2'b00, ADDR_WB0 = 2'b01, ADDR_WB1 = 2'b10
//   - datain_sel constants DIN_CPU = 1'b0, DIN_PMEM = 1'b1
// - One sub-module, sat_counter #(WIDTH): synchronous clear on rst, inc input, saturates; instantiated three times.
// TESTING
// - Read hit: mem_read = 1, hit0 = 1 -> same-cycle mem_resp = 1, load_lru = 1, no data/tag strobes; hit_count = 1.
// - Write hit: mem_write = 1, hit1 = 1 -> mem_resp = 1, load_data1 = load_dirty1 = 1, datain_sel = 0, load_lru = 1.
// - Clean miss: lru_out = 0, dirty0 = 0; pmem_resp after 5 cycles.
//   - pmem_read = 1 with addr_sel = 00 for 5 cycles.
//   - In the resp cycle: load_data0/tag0/valid0/dirty0 = 1, datain_sel = 1.
//   - mem_resp one cycle later; miss_count = 1, hit_count = 0.
// - Dirty miss: lru_out = 1, dirty1 = 1.
//   - pmem_write = 1 with addr_sel = 10 until pmem_resp.
//   - Then pmem_read = 1 with addr_sel = 00; fill lands in way1; wb_count = 1.
// - Reset mid-ALLOCATE: 1-cycle rst at cycle 3 of the fill -> pmem_read = 0 next cycle, counters = 0, no array strobes.
// - Saturation: CNT_WIDTH = 4, 20 consecutive read hits -> hit_count = 15.

Source files
------------

// File: rtl/cache_types_pkg.sv
// Shared types and encodings for the 2-way set-associative cache controller.
// Contents:
//   state_t    : controller FSM states (IDLE, WRITEBACK, ALLOCATE)
//   ADDR_*     : encodings of the pmem address select driven to the datapath
//   DIN_*      : encodings of the array data-in select driven to the datapath
package cache_types;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WRITEBACK = 2'b01,
    ST_ALLOCATE  = 2'b10
  } state_t;

  // pmem address select
  localparam logic [1:0] ADDR_CPU = 2'b00;  // CPU line address (fill)
  localparam logic [1:0] ADDR_WB0 = 2'b01;  // {tag0, set} (writeback of way0)
  localparam logic [1:0] ADDR_WB1 = 2'b10;  // {tag1, set} (writeback of way1)

  // array data-in select
  localparam logic DIN_CPU  = 1'b0;  // CPU write merge, sets dirty
  localparam logic DIN_PMEM = 1'b1;  // line fill from pmem, clears dirty

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the cache performance counters.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high clear
//   inc   : count one event this cycle
//   count : current value; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count events, clearing on reset and sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {WIDTH{1'b0}};
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/cache_control.sv
// Control FSM for a 2-way set-associative cache. Sits between the CPU memory
// port and physical memory and drives every datapath strobe combinationally.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   mem_read/mem_write/mem_resp   : CPU request handshake
//   pmem_read/pmem_write/pmem_resp: physical memory line transaction
//   hit0/hit1, dirty0/dirty1,
//   lru_out                       : datapath status for the indexed set
//   load_*0/1, load_lru           : datapath array write enables
//   addr_sel, datain_sel          : datapath muxes
//   hit_count/miss_count/wb_count : saturating performance counters
module cache_control
  import cache_types::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  input  logic                 pmem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 hit0,
  input  logic                 hit1,
  input  logic                 dirty0,
  input  logic                 dirty1,
  input  logic                 lru_out,
  output logic                 load_valid0,
  output logic                 load_valid1,
  output logic                 load_dirty0,
  output logic                 load_dirty1,
  output logic                 load_tag0,
  output logic                 load_tag1,
  output logic                 load_data0,
  output logic                 load_data1,
  output logic                 load_lru,
  output logic [1:0]           addr_sel,
  output logic                 datain_sel,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  state_t r_state;
  logic   r_victim;  // way chosen for replacement, frozen for the whole miss
  logic   r_replay;  // set after a fill so the replayed hit is not counted

  logic w_req;
  logic w_hit;
  logic w_victim_dirty;
  logic w_hit_inc;
  logic w_miss_inc;
  logic w_wb_inc;

  assign w_req          = mem_read | mem_write;
  assign w_hit          = hit0 | hit1;
  assign w_victim_dirty = lru_out ? dirty1 : dirty0;

  // State, victim and replay flag sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_victim <= 1'b0;
      r_replay <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req && w_hit) begin
            r_replay <= 1'b0;
          end else if (w_req) begin
            r_victim <= lru_out;
            r_state  <= w_victim_dirty ? ST_WRITEBACK : ST_ALLOCATE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WRITEBACK: begin
          if (pmem_resp) begin
            r_state <= ST_ALLOCATE;
          end else begin
            r_state <= ST_WRITEBACK;
          end
        end
        ST_ALLOCATE: begin
          if (pmem_resp) begin
            r_state  <= ST_IDLE;
            r_replay <= 1'b1;
          end else begin
            r_state <= ST_ALLOCATE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Datapath strobes and counter increments decoded from state and inputs.
  always_comb begin
    mem_resp    = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    load_valid0 = 1'b0;
    load_valid1 = 1'b0;
    load_dirty0 = 1'b0;
    load_dirty1 = 1'b0;
    load_tag0   = 1'b0;
    load_tag1   = 1'b0;
    load_data0  = 1'b0;
    load_data1  = 1'b0;
    load_lru    = 1'b0;
    addr_sel    = ADDR_CPU;
    datain_sel  = DIN_CPU;
    w_hit_inc   = 1'b0;
    w_miss_inc  = 1'b0;
    w_wb_inc    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req && w_hit) begin
          mem_resp  = 1'b1;
          load_lru  = 1'b1;
          w_hit_inc = ~r_replay;
          // A write wins over a simultaneous read; way0 wins a double hit.
          if (mem_write && hit0) begin
            load_data0 = 1'b1;
            load_dirty0 = 1'b1;
          end else if (mem_write) begin
            load_data1 = 1'b1;
            load_dirty1 = 1'b1;
          end else begin
            load_data0 = 1'b0;
          end
        end else if (w_req) begin
          w_miss_inc = 1'b1;
        end else begin
          w_miss_inc = 1'b0;
        end
      end
      ST_WRITEBACK: begin
        pmem_write = 1'b1;
        addr_sel   = r_victim ? ADDR_WB1 : ADDR_WB0;
        w_wb_inc   = pmem_resp;
      end
      ST_ALLOCATE: begin
        pmem_read = 1'b1;
        // The fill is never written while reset is being applied.
        if (pmem_resp && !rst) begin
          datain_sel  = DIN_PMEM;
          load_data0  = ~r_victim;
          load_tag0   = ~r_victim;
          load_valid0 = ~r_victim;
          load_dirty0 = ~r_victim;
          load_data1  = r_victim;
          load_tag1   = r_victim;
          load_valid1 = r_victim;
          load_dirty1 = r_victim;
        end else begin
          datain_sel = DIN_CPU;
        end
      end
      default: begin
        mem_resp = 1'b0;
      end
    endcase
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk(clk), .rst(rst), .inc(w_hit_inc), .count(hit_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk(clk), .rst(rst), .inc(w_miss_inc), .count(miss_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
    .clk(clk), .rst(rst), .inc(w_wb_inc), .count(wb_count)
  );

endmodule

// File: tb/tb_cache_control.sv
// Directed self-checking bench for cache_control (counters 4 bits wide so
// saturation is reachable quickly).
module tb_cache_control;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, mem_read, mem_write, pmem_resp;
  logic         hit0, hit1, dirty0, dirty1, lru_out;
  logic         mem_resp, pmem_read, pmem_write;
  logic         load_valid0, load_valid1, load_dirty0, load_dirty1;
  logic         load_tag0, load_tag1, load_data0, load_data1, load_lru;
  logic [1:0]   addr_sel;
  logic         datain_sel;
  logic [W-1:0] hit_count, miss_count, wb_count;

  int checks = 0;
  int errors = 0;

  cache_control #(.CNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .pmem_resp(pmem_resp), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .hit0(hit0), .hit1(hit1), .dirty0(dirty0),
    .dirty1(dirty1), .lru_out(lru_out), .load_valid0(load_valid0),
    .load_valid1(load_valid1), .load_dirty0(load_dirty0),
    .load_dirty1(load_dirty1), .load_tag0(load_tag0), .load_tag1(load_tag1),
    .load_data0(load_data0), .load_data1(load_data1), .load_lru(load_lru),
    .addr_sel(addr_sel), .datain_sel(datain_sel), .hit_count(hit_count),
    .miss_count(miss_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are then driven 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    hit0 = 1'b0; hit1 = 1'b0; dirty0 = 1'b0; dirty1 = 1'b0; lru_out = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] strobes();
    return {load_data0, load_tag0, load_valid0, load_dirty0,
            load_data1, load_tag1, load_valid1, load_dirty1};
  endfunction

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({mem_resp, pmem_read, pmem_write, load_lru} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs got %b want 0000", {mem_resp, pmem_read, pmem_write, load_lru});
    end
    checks++;
    if ({hit_count, miss_count, wb_count} !== {3*W{1'b0}}) begin
      errors++; $display("FAIL reset_counters got %h/%h/%h want 0", hit_count, miss_count, wb_count);
    end
  endtask

  task automatic test_read_hit();
    do_reset();
    mem_read = 1'b1; hit0 = 1'b1;
    #1;
    checks++;
    if ({mem_resp, load_lru, strobes()} !== 10'b11_00000000) begin
      errors++; $display("FAIL read_hit got %b want 1100000000", {mem_resp, load_lru, strobes()});
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (hit_count !== 4'd1) begin
      errors++; $display("FAIL read_hit_count got %0d want 1", hit_count);
    end
  endtask

  task automatic test_write_hit();
    do_reset();
    mem_write = 1'b1; hit1 = 1'b1;
    #1;
    checks++;
    if ({mem_resp, load_lru, datain_sel, strobes()} !== 11'b110_00001001) begin
      errors++; $display("FAIL write_hit got %b want 11000001001", {mem_resp, load_lru, datain_sel, strobes()});
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_illegal_inputs();
    do_reset();
    // Both requests plus both hits: treated as a write to way0.
    mem_read = 1'b1; mem_write = 1'b1; hit0 = 1'b1; hit1 = 1'b1;
    #1;
    checks++;
    if ({mem_resp, datain_sel, strobes()} !== 10'b10_10010000) begin
      errors++; $display("FAIL illegal_combo got %b want 1010010000", {mem_resp, datain_sel, strobes()});
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_clean_miss();
    do_reset();
    mem_read = 1'b1; lru_out = 1'b0; dirty0 = 1'b0; dirty1 = 1'b1;
    #1;
    checks++;
    if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin
      errors++; $display("FAIL clean_miss_idle got %b want 000", {mem_resp, pmem_read, pmem_write});
    end
    tick();
    lru_out = 1'b1;  // must not move the already-latched victim
    for (int i = 1; i <= 5; i++) begin
      pmem_resp = (i == 5);
      #1;
      checks++;
      if ({pmem_read, pmem_write, addr_sel, mem_resp} !== 5'b10000) begin
        errors++; $display("FAIL clean_miss_pmem cyc %0d got %b want 10000", i, {pmem_read, pmem_write, addr_sel, mem_resp});
      end
      if (i == 5) begin
        checks++;
        if ({datain_sel, strobes()} !== 9'b1_11110000) begin
          errors++; $display("FAIL clean_miss_fill got %b want 111110000", {datain_sel, strobes()});
        end
      end else begin
        checks++;
        if (strobes() !== 8'b0) begin
          errors++; $display("FAIL clean_miss_early_strobe cyc %0d got %b want 0", i, strobes());
        end
      end
      tick();
    end
    pmem_resp = 1'b0; hit0 = 1'b1;
    #1;
    checks++;
    if ({mem_resp, load_lru, pmem_read} !== 3'b110) begin
      errors++; $display("FAIL clean_miss_replay got %b want 110", {mem_resp, load_lru, pmem_read});
    end
    tick();
    checks++;
    if ({hit_count, miss_count} !== {4'd0, 4'd1}) begin
      errors++; $display("FAIL clean_miss_counts hit %0d miss %0d want 0 1", hit_count, miss_count);
    end
    // Replay is consumed: the next hit counts.
    tick();
    clear_inputs();
    checks++;
    if (hit_count !== 4'd1) begin
      errors++; $display("FAIL post_replay_hit got %0d want 1", hit_count);
    end
  endtask

  task automatic test_dirty_miss();
    do_reset();
    mem_read = 1'b1; lru_out = 1'b1; dirty1 = 1'b1; dirty0 = 1'b0;
    tick();
    lru_out = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      pmem_resp = (i == 3);
      #1;
      checks++;
      if ({pmem_write, pmem_read, addr_sel, strobes()} !== 12'b1010_00000000) begin
        errors++; $display("FAIL dirty_miss_wb cyc %0d got %b want 101000000000", i, {pmem_write, pmem_read, addr_sel, strobes()});
      end
      tick();
    end
    checks++;
    if (wb_count !== 4'd1) begin
      errors++; $display("FAIL dirty_miss_wb_count got %0d want 1", wb_count);
    end
    for (int i = 1; i <= 2; i++) begin
      pmem_resp = (i == 2);
      #1;
      checks++;
      if ({pmem_read, pmem_write, addr_sel} !== 4'b1000) begin
        errors++; $display("FAIL dirty_miss_alloc cyc %0d got %b want 1000", i, {pmem_read, pmem_write, addr_sel});
      end
      tick();
      if (i == 1) begin
        checks++;
        if (strobes() !== 8'b0) begin
          errors++; $display("FAIL dirty_miss_early_strobe got %b want 0", strobes());
        end
      end
    end
    pmem_resp = 1'b0; hit1 = 1'b1;
    #1;
    checks++;
    if (mem_resp !== 1'b1) begin
      errors++; $display("FAIL dirty_miss_replay got %b want 1", mem_resp);
    end
    tick();
    clear_inputs();
    checks++;
    if ({hit_count, miss_count, wb_count} !== {4'd0, 4'd1, 4'd1}) begin
      errors++; $display("FAIL dirty_miss_counts got %0d/%0d/%0d want 0/1/1", hit_count, miss_count, wb_count);
    end
  endtask

  task automatic test_dirty_miss_fill_way1();
    // Separate check of the way1 fill strobes at the resp cycle.
    do_reset();
    mem_write = 1'b1; lru_out = 1'b1; dirty1 = 1'b0;
    tick();
    pmem_resp = 1'b1;
    #1;
    checks++;
    if ({datain_sel, strobes()} !== 9'b1_00001111) begin
      errors++; $display("FAIL fill_way1 got %b want 100001111", {datain_sel, strobes()});
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_writeback_way0();
    do_reset();
    mem_write = 1'b1; lru_out = 1'b0; dirty0 = 1'b1;
    tick();
    #1;
    checks++;
    if ({pmem_write, addr_sel} !== 3'b101) begin
      errors++; $display("FAIL wb_way0 got %b want 101", {pmem_write, addr_sel});
    end
    do_reset();
  endtask

  task automatic test_reset_mid_alloc();
    do_reset();
    mem_read = 1'b1; lru_out = 1'b0; dirty0 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;  // cycle 3 of the fill
    #1;
    checks++;
    if ({pmem_read, strobes()} !== 9'b1_00000000) begin
      errors++; $display("FAIL reset_alloc_during got %b want 100000000", {pmem_read, strobes()});
    end
    tick();
    rst = 1'b0;
    mem_read = 1'b0;
    #1;
    checks++;
    if ({pmem_read, pmem_write, mem_resp, strobes()} !== 11'b0) begin
      errors++; $display("FAIL reset_alloc_after got %b want 0", {pmem_read, pmem_write, mem_resp, strobes()});
    end
    checks++;
    if ({hit_count, miss_count, wb_count} !== {3*W{1'b0}}) begin
      errors++; $display("FAIL reset_alloc_counters got %0d/%0d/%0d want 0", hit_count, miss_count, wb_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    mem_read = 1'b1; hit0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    clear_inputs();
    checks++;
    if (hit_count !== 4'd15) begin
      errors++; $display("FAIL saturation got %0d want 15", hit_count);
    end
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    #2;
    test_reset();
    test_read_hit();
    test_write_hit();
    test_illegal_inputs();
    test_clean_miss();
    test_dirty_miss();
    test_dirty_miss_fill_way1();
    test_writeback_way0();
    test_reset_mid_alloc();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
